pll_reconfig_ctrl: RTL and testbench
====================================

PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 Parameter: LOCK_TIMEOUT, 65535, cycles waited for pll_locked before abort; used only with the macro in REQ-030.
REQ-002 pclk  input  1  board clock; all logic is on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  reconfiguration request.
REQ-005 req_ready  output  1  high only in IDLE.
REQ-006 req_mult  input  7  feedback multiplier; legal range 2..64.
REQ-007 req_div  input  8  CLKOUT0 divider; legal range 1..128.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 done  output  1  one-cycle pulse marking the end of a request.
REQ-010 err  output  1  valid with done: 1 = rejected or aborted.
REQ-011 drp_daddr  output  7  DRP address.
REQ-012 drp_den  output  1  DRP enable; one-cycle pulse.
REQ-013 drp_dwe  output  1  DRP write enable; asserted only together with drp_den.
REQ-014 drp_di  output  16  DRP write data.
REQ-015 drp_do  input  16  DRP read data; valid when drp_drdy is high.
REQ-016 drp_drdy  input  1  DRP access complete.
REQ-017 pll_rst  output  1  drives the PLL RST pin.
REQ-018 pll_locked  input  1  PLL LOCKED.

Function
REQ-019 A request is accepted on any cycle where req_valid and req_ready are both high; req_mult and req_div are captured on that cycle.
- req_valid during busy is ignored.
REQ-020 If a captured value is out of range, the request is rejected:
- go to DONE on the next cycle, with done=1 and err=1;
- pll_rst and the DRP outputs do not toggle.
REQ-021 State machine:
- IDLE -> RST (accept) -> RD -> RD_WAIT -> WR -> WR_WAIT -> (next register: RD | last register: UNRST) -> LOCK_WAIT -> DONE -> IDLE.
REQ-022 Register order:
- 0x08 (CLKOUT0 reg1), then 0x09 (CLKOUT0 reg2), then 0x14 (CLKFBOUT reg1), then 0x15 (CLKFBOUT reg2).
- The 2-bit register index wraps only after 0x15.
REQ-023 pll_rst:
- set to 1 on entry to RST;
- held at 1 through all DRP accesses;
- cleared on entry to LOCK_WAIT.
REQ-024 In RD and WR, drp_den=1 for exactly one cycle.
- The machine stays in RD_WAIT or WR_WAIT until drp_drdy=1.
- drp_drdy in any other state is ignored.
REQ-025 Divider encoding for value N (N = req_mult or req_div):
- N=1: high=1, low=1, edge=0, no_count=1;
- otherwise: high=N>>1, low=N-high, edge=N[0], no_count=0.
REQ-026 Write data is read-modify-write of the drp_do value captured in RD_WAIT:
- reg1: di = {do[15:12], high[5:0], low[5:0]};
- reg2: di = {do[15:8], edge, no_count, do[5:0]}.
REQ-027 LOCK_WAIT exits to DONE on the first cycle pll_locked=1, with done=1 and err=0.
REQ-028 done is asserted only in DONE.
- req_ready returns to 1 on the cycle after DONE.

Reset
REQ-029 While resetn=0:
- state=IDLE, req_ready=1, busy=0, done=0, err=0;
- drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0;
- pll_rst=1.
On release, pll_rst clears on the first pclk edge.
- Reset mid-sequence abandons the transfer with no completion pulse.

Configuration
REQ-030 Macro PLL_RECONFIG_TIMEOUT_EN.
- Defined: a counter runs in LOCK_WAIT. If pll_locked is still 0 after LOCK_TIMEOUT cycles, the machine goes to DONE with err=1. pll_rst stays 0.
- Undefined: there is no counter, and LOCK_WAIT waits indefinitely.

Verification
REQ-031 mult=10, div=10, drp_do=0xF000 on every read, drp_drdy 2 cycles after each den, locked 20 cycles after UNRST -> writes 0x08=0xF145, 0x09=0xF000, 0x14=0xF145, 0x15=0xF000; done=1, err=0.
REQ-032 mult=7, div=1, drp_do=0x0000 -> writes 0x08=0x0041, 0x09=0x0040, 0x14=0x00C4, 0x15=0x0080.
REQ-033 mult=65 or div=0 -> done=1 and err=1 two cycles after acceptance; drp_den never asserted; pll_rst stays 0.
REQ-034 req_valid held high during busy, then resetn pulsed low mid-way through RD_WAIT at 0x14 -> exactly one request accepted before reset; pll_rst=1 while resetn=0; IDLE after reset; no done pulse.
REQ-035 Macro defined, LOCK_TIMEOUT=100, pll_locked tied 0 -> done=1 and err=1 exactly 100 cycles after LOCK_WAIT entry; macro undefined -> busy remains high.

Source files
------------

// File: rtl/pll_reconfig_ctrl.sv
//==============================================================================
// Module   : pll_reconfig_ctrl
// Brief    : DRP read-modify-write sequencer that retunes the PLL CLKOUT0 and
//            CLKFBOUT dividers. Optional lock timeout: PLL_RECONFIG_TIMEOUT_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pll_reconfig_ctrl #(
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        pclk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  req_mult,
  input  logic [7:0]  req_div,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  output logic        drp_dwe,
  output logic [15:0] drp_di,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic        pll_rst,
  input  logic        pll_locked
);

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_UNRST, S_LOCK_WAIT, S_DONE
  } state_t;

  state_t      state_q;
  logic [1:0]  idx_q;
  logic [6:0]  mult_q;
  logic [7:0]  div_q;
  logic        bad_q;
  logic        req_ready_q, busy_q, done_q, err_q;
  logic [6:0]  drp_daddr_q;
  logic        drp_den_q, drp_dwe_q, pll_rst_q;
  logic [15:0] drp_di_q;

  logic        w_in_range;
  logic [7:0]  w_n;
  logic [13:0] w_enc;
  logic [15:0] w_rmw;

  // Packed as {edge, no_count, high[5:0], low[5:0]}.
  function automatic logic [13:0] f_encode(input logic [7:0] n);
    logic [7:0] hi, lo;
    if (n == 8'd1) begin
      f_encode = {1'b0, 1'b1, 6'd1, 6'd1};
    end else begin
      hi = n >> 1;
      lo = n - hi;
      f_encode = {n[0], 1'b0, hi[5:0], lo[5:0]};
    end
  endfunction

  function automatic logic [6:0] f_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    f_addr = 7'h08;
      2'd1:    f_addr = 7'h09;
      2'd2:    f_addr = 7'h14;
      default: f_addr = 7'h15;
    endcase
  endfunction

  assign w_in_range = (req_mult >= 7'd2) && (req_mult <= 7'd64) &&
                      (req_div != 8'd0) && (req_div <= 8'd128);

  // Indices 0/1 address CLKOUT0 (divider), 2/3 address CLKFBOUT (multiplier).
  assign w_n   = idx_q[1] ? {1'b0, mult_q} : div_q;
  assign w_enc = f_encode(w_n);
  assign w_rmw = idx_q[0] ? ((drp_do & 16'hFF3F) | {8'h00, w_enc[13:12], 6'h00})
                          : ((drp_do & 16'hF000) | {4'h0, w_enc[11:0]});

`ifdef PLL_RECONFIG_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);
  logic [CNT_W-1:0] lock_cnt_q;
`endif

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      mult_q      <= 7'd0;
      div_q       <= 8'd0;
      bad_q       <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      drp_daddr_q <= 7'd0;
      drp_den_q   <= 1'b0;
      drp_dwe_q   <= 1'b0;
      drp_di_q    <= 16'd0;
      pll_rst_q   <= 1'b1;
`ifdef PLL_RECONFIG_TIMEOUT_EN
      lock_cnt_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          pll_rst_q <= 1'b0;
          if (req_valid) begin
            mult_q      <= req_mult;
            div_q       <= req_div;
            bad_q       <= ~w_in_range;
            pll_rst_q   <= w_in_range;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            err_q       <= 1'b0;
            state_q     <= S_RST;
          end
        end
        S_RST: begin
          if (bad_q) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q       <= 2'd0;
            drp_daddr_q <= f_addr(2'd0);
            drp_den_q   <= 1'b1;
            drp_dwe_q   <= 1'b0;
            state_q     <= S_RD;
          end
        end
        S_RD: begin
          drp_den_q <= 1'b0;
          state_q   <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (drp_drdy) begin
            drp_di_q  <= w_rmw;
            drp_den_q <= 1'b1;
            drp_dwe_q <= 1'b1;
            state_q   <= S_WR;
          end
        end
        S_WR: begin
          drp_den_q <= 1'b0;
          drp_dwe_q <= 1'b0;
          state_q   <= S_WR_WAIT;
        end
        S_WR_WAIT: begin
          if (drp_drdy) begin
            if (idx_q == 2'd3) begin
              state_q <= S_UNRST;
            end else begin
              idx_q       <= idx_q + 2'd1;
              drp_daddr_q <= f_addr(idx_q + 2'd1);
              drp_den_q   <= 1'b1;
              state_q     <= S_RD;
            end
          end
        end
        S_UNRST: begin
          pll_rst_q <= 1'b0;
`ifdef PLL_RECONFIG_TIMEOUT_EN
          lock_cnt_q <= '0;
`endif
          state_q   <= S_LOCK_WAIT;
        end
        S_LOCK_WAIT: begin
          if (pll_locked) begin
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            state_q <= S_DONE;
          end
`ifdef PLL_RECONFIG_TIMEOUT_EN
          else if (lock_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
          end else begin
            lock_cnt_q <= lock_cnt_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          err_q       <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign drp_daddr = drp_daddr_q;
  assign drp_den   = drp_den_q;
  assign drp_dwe   = drp_dwe_q;
  assign drp_di    = drp_di_q;
  assign pll_rst   = pll_rst_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reconfig_ctrl.sv
//==============================================================================
// Module   : tb_pll_reconfig_ctrl
// Brief    : Directed self-checking bench with a DRP responder and PLL lock model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pll_reconfig_ctrl;

  logic        pclk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [6:0]  req_mult = 7'd0;
  logic [7:0]  req_div = 8'd0;
  logic [15:0] drp_do = 16'd0;
  logic        drp_drdy = 1'b0;
  logic        pll_locked = 1'b0;
  logic        req_ready, busy, done, err, drp_den, drp_dwe, pll_rst;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;

  int checks = 0;
  int failures = 0;

  pll_reconfig_ctrl #(.LOCK_TIMEOUT(100)) dut (
    .pclk(pclk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_mult(req_mult), .req_div(req_div), .busy(busy), .done(done), .err(err),
    .drp_daddr(drp_daddr), .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .pll_rst(pll_rst), .pll_locked(pll_locked)
  );

  initial forever #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // DRP responder (drdy two cycles after each den) and PLL lock model.
  logic [15:0] rd_val = 16'h0000;
  logic [6:0]  wr_addr[$];
  logic [15:0] wr_data[$];
  int  dly = 0, den_cnt = 0, dwe_bad = 0, done_cnt = 0, rst_hi = 0, lock_dly = 0;
  int  acc_cnt = 0;
  bit  lock_en = 1'b1;
  logic prev_rst = 1'b1;

  initial forever begin
    @(posedge pclk); #1;
    drp_drdy = 1'b0;
    if (dly > 0) begin
      dly--;
      if (dly == 0) begin
        drp_drdy = 1'b1;
        drp_do   = rd_val;
      end
    end
    if (drp_den) begin
      den_cnt++;
      dly = 2;
      if (drp_dwe) begin
        wr_addr.push_back(drp_daddr);
        wr_data.push_back(drp_di);
      end
    end
    if (drp_dwe && !drp_den) dwe_bad++;
    if (done) done_cnt++;
    if (pll_rst && resetn) rst_hi++;
    if (pll_rst) begin
      pll_locked = 1'b0;
      lock_dly   = 0;
    end else if (prev_rst) begin
      lock_dly = 20;
    end else if (lock_dly > 0) begin
      lock_dly--;
      if (lock_dly == 0) pll_locked = lock_en;
    end
    prev_rst = pll_rst;
  end

  initial forever begin
    @(negedge pclk); #1;
    if (resetn && req_valid && req_ready) acc_cnt++;
  end

  task automatic send(input logic [6:0] m, input logic [7:0] d);
    @(negedge pclk);
    req_valid = 1'b1; req_mult = m; req_div = d;
    @(negedge pclk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    bit seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(posedge pclk); #1;
      if (done) seen = 1'b1;
    end
    chk("done_within_bound", {31'd0, seen}, 32'd1);
  endtask

  task automatic run_xfer(input string tag, input logic [6:0] m, input logic [7:0] d,
                          input logic [15:0] rv, input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3);
    logic [6:0]  ea[4];
    logic [15:0] ed[4];
    ea[0] = 7'h08; ea[1] = 7'h09; ea[2] = 7'h14; ea[3] = 7'h15;
    ed[0] = e0; ed[1] = e1; ed[2] = e2; ed[3] = e3;
    rd_val = rv;
    wr_addr.delete(); wr_data.delete();
    send(m, d);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
    chk({tag, "_pll_rst_set"}, {31'd0, pll_rst}, 32'd1);
    wait_done(2000);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_pll_rst_clear"}, {31'd0, pll_rst}, 32'd0);
    chk({tag, "_nwrites"}, wr_addr.size(), 32'd4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), {25'd0, wr_addr[i]}, {25'd0, ea[i]});
      chk($sformatf("%s_data%0d", tag, i), {16'd0, wr_data[i]}, {16'd0, ed[i]});
    end
    @(posedge pclk); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic run_reject(input string tag, input logic [6:0] m, input logic [7:0] d);
    int den0, rh0;
    den0 = den_cnt; rh0 = rst_hi;
    send(m, d);
    chk({tag, "_done_not_yet"}, {31'd0, done}, 32'd0);
    @(posedge pclk); #1;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_err"}, {31'd0, err}, 32'd1);
    @(posedge pclk); #1;
    chk({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_no_den"}, den_cnt - den0, 32'd0);
    chk({tag, "_no_pll_rst"}, rst_hi - rh0, 32'd0);
  endtask

  initial begin
    int acc0, done0, n;
    bit seen;

    // Reset state
    #12;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_den", {31'd0, drp_den}, 32'd0);
    chk("rst_dwe", {31'd0, drp_dwe}, 32'd0);
    chk("rst_daddr", {25'd0, drp_daddr}, 32'd0);
    chk("rst_di", {16'd0, drp_di}, 32'd0);
    chk("rst_pll_rst", {31'd0, pll_rst}, 32'd1);
    @(negedge pclk); resetn = 1'b1;
    @(posedge pclk); #1;
    chk("rel_pll_rst_clear", {31'd0, pll_rst}, 32'd0);

    // Main transfers
    run_xfer("m10d10", 7'd10, 8'd10, 16'hF000, 16'hF145, 16'hF000, 16'hF145, 16'hF000);
    run_xfer("m7d1", 7'd7, 8'd1, 16'h0000, 16'h0041, 16'h0040, 16'h00C4, 16'h0080);
    run_xfer("m64d128", 7'd64, 8'd128, 16'hFFFF, 16'hF000, 16'hFF3F, 16'hF820, 16'hFF3F);
    chk("dwe_only_with_den", dwe_bad, 32'd0);

    // Out-of-range requests
    run_reject("rej_m65", 7'd65, 8'd10);
    run_reject("rej_d0", 7'd10, 8'd0);
    run_reject("rej_m1", 7'd1, 8'd10);

    // Held req_valid, then reset in RD_WAIT of 0x14
    acc0 = acc_cnt; done0 = done_cnt; rd_val = 16'hF000;
    @(negedge pclk);
    req_valid = 1'b1; req_mult = 7'd10; req_div = 8'd10;
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge pclk); #1;
      if (drp_den && !drp_dwe && drp_daddr == 7'h14) seen = 1'b1;
    end
    chk("midrst_reach_rd14", {31'd0, seen}, 32'd1);
    @(posedge pclk);
    @(negedge pclk);
    resetn = 1'b0; req_valid = 1'b0;
    #1;
    chk("midrst_pll_rst", {31'd0, pll_rst}, 32'd1);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_den", {31'd0, drp_den}, 32'd0);
    @(posedge pclk); @(posedge pclk);
    @(negedge pclk); resetn = 1'b1;
    chk("midrst_one_accept", acc_cnt - acc0, 32'd1);
    for (int i = 0; i < 40; i++) @(posedge pclk);
    #1;
    chk("midrst_no_done", done_cnt - done0, 32'd0);
    chk("midrst_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("midrst_idle_busy", {31'd0, busy}, 32'd0);

    // Lock never arrives
    lock_en = 1'b0; rd_val = 16'h0000; done0 = done_cnt;
    send(7'd10, 8'd10);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(posedge pclk); #1;
      if (!pll_rst) seen = 1'b1;
    end
    chk("to_reach_lock_wait", {31'd0, seen}, 32'd1);
    n = 0; seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(posedge pclk); #1;
      n++;
      if (done) seen = 1'b1;
    end
`ifdef PLL_RECONFIG_TIMEOUT_EN
    chk("to_done_seen", {31'd0, seen}, 32'd1);
    chk("to_cycles", n, 32'd100);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_pll_rst_low", {31'd0, pll_rst}, 32'd0);
`else
    chk("to_no_done", done_cnt - done0, 32'd0);
    chk("to_busy_held", {31'd0, busy}, 32'd1);
`endif
    @(negedge pclk); resetn = 1'b0;
    @(negedge pclk); resetn = 1'b1; lock_en = 1'b1;
    @(posedge pclk); #1;
    chk("final_idle", {31'd0, req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
